mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: cycles in BUSY without dm_ack before abort; legal range 1..(2^TO_W-1).
REQ-002 The block SHALL have parameter TO_W, default 8: width of the timeout counter.
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports in_valid in 1, mem_read in 1, mem_write in 1: instruction present; load; store.
REQ-006 The block SHALL have ports mem_size in 2 (0 byte, 1 half, 2 word, 3 treated as word) and mem_unsigned in 1 (zero-extend loads).
REQ-007 The block SHALL have ports addr in 32 (ALU result) and wdata in 32 (store data).
REQ-008 The block SHALL have ports flush in 1 (kill current instruction) and out_ready in 1 (stage-4 register enable).
REQ-009 The block SHALL have ports dm_req out 1, dm_we out 1, dm_addr out 32 (low 2 bits zero), dm_be out 4, dm_wdata out 32, dm_rdata in 32, dm_ack in 1.
REQ-010 The block SHALL have ports rdata out 32 (to stage-4 datamem_data), stall out 1, bus_err out 1, misalign out 1.

Function
REQ-011 Memory op = in_valid & (mem_read | mem_write); both set SHALL be a store, rdata 0.
REQ-012 Non-memory instruction SHALL pass with zero latency: stall 0, dm_req 0, rdata 0.
REQ-013 FSM states SHALL be IDLE, BUSY, DONE.
REQ-014 IDLE: memory op & !flush -> latch dm_addr/dm_we/dm_be/dm_wdata, go BUSY; stall 1 combinationally that cycle.
REQ-015 BUSY: dm_req 1, latched request fields held stable, stall 1; dm_ack -> capture rdata, go DONE.
REQ-016 DONE: dm_req 0, stall 0, rdata held; out_ready -> IDLE; !out_ready -> stay, rdata unchanged.
REQ-017 Loads: byte lane addr[1:0], half lane addr[1], little-endian; sign-extend unless mem_unsigned; word unmodified.
REQ-018 Stores: dm_be byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],0}, word 4'b1111; dm_wdata byte/half replicated to all lanes; stores also wait for dm_ack; rdata 0.
REQ-019 Flush in IDLE SHALL issue nothing; flush in DONE SHALL go IDLE, rdata 0.
REQ-020 Flush in BUSY SHALL NOT drop dm_req; SHALL set discard flag; on dm_ack go IDLE, rdata unchanged; stall stays 1 until then.
REQ-021 Timeout counter SHALL clear on BUSY entry, increment each BUSY cycle without dm_ack; reaching TIMEOUT_CYCLES -> drop dm_req, go DONE, rdata 0, bus_err 1 while in DONE.
REQ-022 dm_ack and timeout in same cycle SHALL take dm_ack; dm_ack outside BUSY SHALL be ignored.
REQ-023 Back-to-back memory ops: DONE & out_ready & next memory op SHALL go IDLE first (one bubble cycle minimum between requests).

Reset
REQ-024 rst SHALL force on next edge: state IDLE, dm_req 0, dm_we 0, dm_be 0, dm_addr 0, dm_wdata 0, rdata 0, bus_err 0, discard 0, counter 0.
REQ-025 rst mid-BUSY SHALL abandon request; later dm_ack ignored.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL NOT issue; misalign 1 same cycle, stall 0, rdata 0.
REQ-027 Without MEM_ALIGN_CHECK_EN: misalign tied 0; half ignores addr[0], word ignores addr[1:0].

Verification
REQ-028 LB addr 0x103, dm_rdata 0x80FF_1234 ack after 3 cycles -> dm_be 4'b1000, stall 4 cycles, rdata 0xFFFF_FF80.
REQ-029 SH addr 0x2002, wdata 0x0000_BEEF -> dm_be 4'b1100, dm_wdata 0xBEEF_BEEF, dm_we 1, rdata 0.
REQ-030 LW, flush in BUSY cycle 2, ack cycle 4 -> dm_req held to cycle 4, then IDLE, rdata unchanged.
REQ-031 LW, no dm_ack, TIMEOUT_CYCLES=4 -> dm_req low after 4 BUSY cycles, bus_err 1, rdata 0.
REQ-032 MEM_ALIGN_CHECK_EN, LW addr 0x6 -> misalign 1, dm_req 0, stall 0; without macro -> dm_addr 0x4, dm_be 4'b1111.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: one data-memory request per load/store, with lane steering,
// load extension, flush/discard handling and a bus timeout. Optional: MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    input  logic        out_ready,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign
);

    // Handshake: dm_req stays high from BUSY entry until the cycle dm_ack is seen
    // (or the timeout fires); request fields are stable for that whole window.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       dm_addr_q, dm_addr_d;
    logic              dm_we_q, dm_we_d;
    logic [3:0]        dm_be_q, dm_be_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              load_q, load_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              discard_q, discard_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic              mem_op;
    logic              misaligned;
    logic              kill;
    logic [TO_W-1:0]   cnt_inc;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [31:0]       load_fmt;

    always_comb begin
        mem_op = in_valid & (mem_read | mem_write);
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = ((mem_size == 2'd1) & addr[0]) |
                     (mem_size[1] & (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif

        case (mem_size)
            2'd0:    be_new = 4'b0001 << addr[1:0];
            2'd1:    be_new = addr[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase

        case (mem_size)
            2'd0:    wdata_new = {4{wdata[7:0]}};
            2'd1:    wdata_new = {2{wdata[15:0]}};
            default: wdata_new = wdata;
        endcase

        case (lane_q)
            2'd0:    load_byte = dm_rdata[7:0];
            2'd1:    load_byte = dm_rdata[15:8];
            2'd2:    load_byte = dm_rdata[23:16];
            default: load_byte = dm_rdata[31:24];
        endcase
        load_half = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

        case (size_q)
            2'd0:    load_fmt = {{24{~uns_q & load_byte[7]}}, load_byte};
            2'd1:    load_fmt = {{16{~uns_q & load_half[15]}}, load_half};
            default: load_fmt = dm_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dm_addr_d  = dm_addr_q;
        dm_we_d    = dm_we_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        lane_d     = lane_q;
        size_d     = size_q;
        uns_d      = uns_q;
        load_d     = load_q;
        rdata_d    = rdata_q;
        bus_err_d  = bus_err_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        kill       = discard_q | flush;
        cnt_inc    = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (mem_op & ~flush & ~misaligned) begin
                    state_d    = S_BUSY;
                    stall      = 1'b1;
                    dm_addr_d  = {addr[31:2], 2'b00};
                    dm_we_d    = mem_write;
                    dm_be_d    = be_new;
                    dm_wdata_d = wdata_new;
                    lane_d     = addr[1:0];
                    size_d     = mem_size;
                    uns_d      = mem_unsigned;
                    load_d     = mem_read & ~mem_write;
                    cnt_d      = '0;
                    discard_d  = 1'b0;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (dm_ack) begin
                    // A killed instruction returns straight to IDLE with rdata untouched.
                    discard_d = 1'b0;
                    if (kill) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DONE;
                        rdata_d   = load_q ? load_fmt : 32'd0;
                        bus_err_d = 1'b0;
                    end
                end else if (cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
                    discard_d = 1'b0;
                    if (kill) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DONE;
                        rdata_d   = 32'd0;
                        bus_err_d = 1'b1;
                    end
                end else begin
                    cnt_d     = cnt_inc;
                    discard_d = kill;
                end
            end
            S_DONE: begin
                if (flush | out_ready) begin
                    state_d   = S_IDLE;
                    rdata_d   = 32'd0;
                    bus_err_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dm_addr_q  <= '0;
            dm_we_q    <= 1'b0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            load_q     <= 1'b0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            discard_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dm_addr_q  <= dm_addr_d;
            dm_we_q    <= dm_we_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            load_q     <= load_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
        end
    end

    assign dm_req   = (state_q == S_BUSY);
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_be    = dm_be_q;
    assign dm_wdata = dm_wdata_q;
    assign rdata    = rdata_q;
    assign bus_err  = bus_err_q;
    assign misalign = (state_q == S_IDLE) & mem_op & misaligned;

endmodule
